// File: rtl/gcd_lcm_stage.sv
// LCM stage fed by a GCD unit: lcm = (A / gcd) * B via a bit-serial restoring divider then shift-add multiplier.
// Optional macro GCD_LCM_REM_CHECK_EN flags a nonzero division remainder as an error.
module gcd_lcm_stage #(
    parameter int op_sz = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [op_sz-1:0]     A,
    input  logic [op_sz-1:0]     B,
    input  logic [op_sz-1:0]     gcd_in,
    input  logic                 gcd_done,
    output logic [2*op_sz-1:0]   lcm,
    output logic                 lcm_valid,
    output logic                 busy,
    output logic                 err
);

    localparam int CW = (op_sz > 1) ? $clog2(op_sz) : 1;
    localparam logic [CW-1:0] LAST = CW'(op_sz - 1);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_MUL, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_done_q;
    logic [CW-1:0]        r_cnt;
    logic [op_sz-1:0]     r_b;
    logic [op_sz-1:0]     r_gcd;
    logic [op_sz-1:0]     r_quo;
    logic [op_sz-1:0]     r_rem;
    logic [2*op_sz-1:0]   r_acc;
    logic [2*op_sz-1:0]   r_mcand;
    logic [2*op_sz-1:0]   r_lcm;
    logic                 r_err;

    logic                 w_capture;
    logic                 w_last;
    logic [op_sz:0]       w_shift;
    logic                 w_sub_ok;
    logic [op_sz-1:0]     w_sub;
    logic [2*op_sz-1:0]   w_acc_sum;
    logic                 w_rem_bad;

    // Only a fresh rising edge seen while idle starts a computation.
    assign w_capture = (r_state == S_IDLE) && gcd_done && !r_done_q;
    assign w_last    = (r_cnt == LAST);

    // r_quo doubles as the dividend shift register; quotient bits enter at the LSB.
    assign w_shift   = {r_rem, r_quo[op_sz-1]};
    assign w_sub_ok  = (w_shift >= {1'b0, r_gcd});
    assign w_sub     = w_shift[op_sz-1:0] - r_gcd;
    assign w_acc_sum = r_quo[0] ? (r_acc + r_mcand) : r_acc;

`ifdef GCD_LCM_REM_CHECK_EN
    assign w_rem_bad = (r_rem != '0);
`else
    assign w_rem_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_capture) begin
                    w_state_next = (gcd_in == '0) ? S_DONE : S_DIV;
                end
            end
            S_DIV:   if (w_last) w_state_next = S_MUL;
            S_MUL:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_q <= 1'b0;
            r_cnt    <= '0;
            r_b      <= '0;
            r_gcd    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_lcm    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_done_q <= gcd_done;
            case (r_state)
                S_IDLE: begin
                    if (w_capture) begin
                        r_b   <= B;
                        r_gcd <= gcd_in;
                        r_quo <= A;
                        r_rem <= '0;
                        r_cnt <= '0;
                        r_err <= (gcd_in == '0);
                        if (gcd_in == '0) begin
                            r_lcm <= '0;
                        end
                    end
                end
                S_DIV: begin
                    r_quo <= {r_quo[op_sz-2:0], w_sub_ok};
                    r_rem <= w_sub_ok ? w_sub : w_shift[op_sz-1:0];
                    r_cnt <= w_last ? '0 : r_cnt + CW'(1);
                    if (w_last) begin
                        r_acc   <= '0;
                        r_mcand <= {{op_sz{1'b0}}, r_b};
                    end
                end
                S_MUL: begin
                    r_acc   <= w_acc_sum;
                    r_quo   <= r_quo >> 1;
                    r_mcand <= r_mcand << 1;
                    r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
                    // Result lands in lcm on entry to DONE so it is valid alongside the pulse.
                    if (w_last) begin
                        r_err <= w_rem_bad;
                        r_lcm <= w_rem_bad ? '0 : w_acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign lcm       = r_lcm;
    assign err       = r_err;
    assign lcm_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);

endmodule

// File: doc/gcd_lcm_stage.md
Name: gcd_lcm_stage

Overview:
- Downstream neighbour of gcd_top. Consumes the same operands A, B plus gcd_top's res/done and produces LCM(A,B) = (A / gcd) * B.
- Sequential datapath: restoring divider followed by shift-add multiplier, one bit per cycle.
- Used wherever both GCD and LCM are needed from one GCD pass.

Parameters:
- op_sz, 8, operand and GCD width in bits; LCM output is 2*op_sz bits.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- A  input  op_sz  first operand, same value presented to gcd_top.
- B  input  op_sz  second operand, same value presented to gcd_top.
- gcd_in  input  op_sz  GCD from gcd_top res.
- gcd_done  input  1  gcd_top done; level or pulse.
- lcm  output  2*op_sz  LCM result; held until next capture.
- lcm_valid  output  1  one-cycle pulse when lcm is updated.
- busy  output  1  high from capture until lcm_valid cycle inclusive.
- err  output  1  error flag for last result; held with lcm.

Behaviour:
- One clock domain (clk). Synchronous active-high reset (rst).
- Reset values:
  - lcm=0, lcm_valid=0, busy=0, err=0.
  - state=IDLE, internal gcd_done_q=0.
- Capture:
  - Register gcd_done_q each cycle.
  - Capture occurs on a rising edge of gcd_done (gcd_done=1, gcd_done_q=0) while in IDLE.
  - A held-high done triggers exactly one computation.
  - Rising edges seen outside IDLE are ignored and never queued.
- States:
  - IDLE: on capture, latch A, B, gcd_in and clear err.
    - If gcd_in==0: go to DONE with lcm=0, err=1.
    - Otherwise: go to DIV with count=0.
  - DIV: restoring division A/gcd, MSB first, one quotient bit per cycle, op_sz cycles. After the last bit, go to MUL.
  - MUL: shift-add quotient*B, one multiplier bit per cycle, op_sz cycles into a 2*op_sz accumulator. After the last bit, go to DONE.
  - DONE: lcm=accumulator (or 0 on err); lcm_valid=1 for this single cycle; then go to IDLE.
- Latency:
  - Normal path: capture edge at cycle 0; lcm_valid high in cycle 2*op_sz+1 (17 for op_sz=8).
  - gcd==0 path: lcm_valid high in cycle 1.
- busy: high in DIV, MUL and DONE; low only in IDLE.
- Width rules:
  - Quotient is op_sz bits; the product fits 2*op_sz bits, so there is no overflow.
  - A==0 or B==0 with gcd≠0 gives lcm=0, err=0.
- Inputs A, B and gcd_in may change after capture without affecting the result.
- Reset mid-operation: the next edge returns all outputs to reset values and the state to IDLE. A gcd_done that is high through reset release counts as a rising edge at release (gcd_done_q=0).
- rst has priority over capture in the same cycle.

Optional Feature:
- Macro: GCD_LCM_REM_CHECK_EN.
- Defined:
  - Final division remainder is checked.
  - Nonzero remainder (gcd_in does not divide A) sets err=1 and lcm=0 at DONE.
  - Latency is unchanged.
- Undefined:
  - Remainder is ignored; err is set only for gcd_in==0.
  - lcm is the truncated-quotient product.

Test Plan:
- A=25, B=15, gcd_in=5, gcd_done rising -> lcm_valid after 17 cycles, lcm=75, err=0, busy high for 17 cycles.
- Back-to-back (12,9,3) then (12,8,4), done held high 2 cycles each -> exactly two lcm_valid pulses, lcm=36 then 24.
- A=255, B=254, gcd_in=1 -> lcm=64770; A=0, B=7, gcd_in=7 -> lcm=0, err=0.
- gcd_in=0 with A=9, B=6 -> lcm_valid in cycle 1, lcm=0, err=1; second gcd_done rising edge during a DIV run is ignored (single result).
- rst asserted at cycle 5 of a (25,15,5) run -> next cycle lcm=0, busy=0, lcm_valid=0; a subsequent (12,9,3) run gives 36.
- With GCD_LCM_REM_CHECK_EN: A=12, B=9, gcd_in=5 -> err=1, lcm=0. Without the macro: same stimulus -> err=0, lcm=18.
